// File: rtl/phyreg_pkg.sv
// rtl/phyreg_pkg.sv - shared widths and types for the physical register file
package phyreg_pkg;

  localparam int XLEN     = 64;
  localparam int PREG_NUM = 64;
  localparam int PREG_W   = 6;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/phyreg_wr_arbiter.sv
// rtl/phyreg_wr_arbiter.sv - priority match of one address against all writeback ports
module phyreg_wr_arbiter #(
  parameter int XLEN   = phyreg_pkg::XLEN,
  parameter int PREG_W = phyreg_pkg::PREG_W,
  parameter int NUM_WR = 4,
  parameter int IDX_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
  input  logic [PREG_W-1:0]        addr_i,
  input  logic [NUM_WR-1:0]        wr_valid_i,
  input  logic [NUM_WR*PREG_W-1:0] wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
  output logic                     hit_o,
  output logic [IDX_W-1:0]         idx_o,
  output logic [XLEN-1:0]          data_o
);

  // Ascending scan so the highest matching port index is the one left standing
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    data_o = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_valid_i[j] && (wr_addr_i[j*PREG_W +: PREG_W] == addr_i)) begin
        hit_o  = 1'b1;
        idx_o  = IDX_W'(j);
        data_o = wr_data_i[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/physical_regfile_mp.sv
// rtl/physical_regfile_mp.sv - multi-port physical register file with bypass and ready scoreboard
module physical_regfile_mp #(
  parameter int XLEN      = phyreg_pkg::XLEN,
  parameter int PREG_NUM  = phyreg_pkg::PREG_NUM,
  parameter int PREG_W    = phyreg_pkg::PREG_W,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 4,
  parameter int NUM_ALLOC = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RD*PREG_W-1:0]    rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]      rd_data_o,
  output logic [NUM_RD-1:0]           rd_ready_o,
  input  logic [NUM_WR-1:0]           wr_valid_i,
  input  logic [NUM_WR*PREG_W-1:0]    wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]      wr_data_i,
  input  logic [NUM_ALLOC-1:0]        alloc_valid_i,
  input  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr_i,
  input  logic                        flush_i,
  output logic                        wr_conflict_o,
  output logic [PREG_W:0]             pending_cnt_o
);

  localparam int IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  logic [XLEN-1:0]     data_q [PREG_NUM];
  logic [PREG_NUM-1:0] ready_q, ready_d;
  logic [PREG_W:0]     pending_q, pending_d;
  logic                conflict_q, conflict_d;

  logic [NUM_RD-1:0]   r_hit;
  logic [IDX_W-1:0]    r_idx  [NUM_RD];
  logic [XLEN-1:0]     r_data [NUM_RD];

  logic [NUM_WR-1:0]   c_hit;
  logic [IDX_W-1:0]    c_idx  [NUM_WR];
  logic [XLEN-1:0]     c_data [NUM_WR];
  logic [NUM_WR-1:0]   wr_en;
  logic [NUM_WR-1:0]   wr_lose;

  // One arbiter per read port supplies the same-cycle bypass value
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_arb
    phyreg_wr_arbiter #(.XLEN(XLEN), .PREG_W(PREG_W), .NUM_WR(NUM_WR), .IDX_W(IDX_W)) u_arb (
      .addr_i     (rd_addr_i[k*PREG_W +: PREG_W]),
      .wr_valid_i (wr_valid_i),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .hit_o      (r_hit[k]),
      .idx_o      (r_idx[k]),
      .data_o     (r_data[k])
    );
  end

  // Each write port checks whether it is the winner for its own address;
  // losing a nonzero-address match means a collision was discarded
  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_arb
    phyreg_wr_arbiter #(.XLEN(XLEN), .PREG_W(PREG_W), .NUM_WR(NUM_WR), .IDX_W(IDX_W)) u_arb (
      .addr_i     (wr_addr_i[j*PREG_W +: PREG_W]),
      .wr_valid_i (wr_valid_i),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .hit_o      (c_hit[j]),
      .idx_o      (c_idx[j]),
      .data_o     (c_data[j])
    );
    assign wr_en[j]   = wr_valid_i[j] && (wr_addr_i[j*PREG_W +: PREG_W] != '0)
                        && c_hit[j] && (c_idx[j] == IDX_W'(j));
    assign wr_lose[j] = wr_valid_i[j] && (wr_addr_i[j*PREG_W +: PREG_W] != '0)
                        && (c_idx[j] != IDX_W'(j));
  end

  assign conflict_d = |wr_lose;

  // Read mux: P0 is zero, then bypass, then storage; reset forces the idle view
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_o[k*XLEN +: XLEN] = '0;
      rd_ready_o[k]             = 1'b1;
      if (rst && (rd_addr_i[k*PREG_W +: PREG_W] != '0)) begin
        if (r_hit[k]) begin
          rd_data_o[k*XLEN +: XLEN] = r_data[k];
        end else begin
          rd_data_o[k*XLEN +: XLEN] = data_q[rd_addr_i[k*PREG_W +: PREG_W]];
          rd_ready_o[k]             = ready_q[rd_addr_i[k*PREG_W +: PREG_W]];
        end
      end
    end
  end

  // Scoreboard next state: later assignments carry higher priority (flush > alloc > writeback)
  always_comb begin
    ready_d = ready_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_valid_i[j]) ready_d[wr_addr_i[j*PREG_W +: PREG_W]] = 1'b1;
    end
    for (int a = 0; a < NUM_ALLOC; a++) begin
      if (alloc_valid_i[a]) ready_d[alloc_addr_i[a*PREG_W +: PREG_W]] = 1'b0;
    end
    if (flush_i) ready_d = '1;
    ready_d[0] = 1'b1;
  end

  // Count of not-ready pregs after this edge
  always_comb begin
    pending_d = '0;
    for (int p = 0; p < PREG_NUM; p++) begin
      pending_d = pending_d + (PREG_W+1)'(!ready_d[p]);
    end
  end

  // Data storage; at most one winning port per address so ordering is irrelevant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < PREG_NUM; p++) data_q[p] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j]) data_q[wr_addr_i[j*PREG_W +: PREG_W]] <= c_data[j];
      end
    end
  end

  // Scoreboard, pending count and collision pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q    <= '1;
      pending_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      pending_q  <= pending_d;
      conflict_q <= conflict_d;
    end
  end

  assign wr_conflict_o = conflict_q;
  assign pending_cnt_o = pending_q;

endmodule
